// File: rtl/conv_control_gen.sv
// Convolution datapath controller: sequences memory reads, address-generator
// enables and MAC accumulate-reload timing across one output frame. It also
// muxes N feature memories onto IFMAP_PAR lanes.

// One mux output lane. It picks the memory owned by the current group, or
// drives zero when it is outside RUN or the memory index is past the end.
module conv_control_gen_lane #(
  parameter int DATA_WIDTH     = 8,
  parameter int INPUT_NUM_MEM  = 5,
  parameter int IFMAP_PAR      = 1,
  parameter int CYCLES_PER_MEM = 9,
  parameter int LANE           = 0,
  parameter int CW             = 1
) (
  input  logic                              run_i,
  input  logic [CW-1:0]                     cnt_i,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] q_a_all_i,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] q_b_all_i,
  output logic [DATA_WIDTH-1:0]             q_a_o,
  output logic [DATA_WIDTH-1:0]             q_b_o
);
  int sel;

  assign sel = (int'(cnt_i) / CYCLES_PER_MEM) * IFMAP_PAR + LANE;

  // Select the memory for this lane; unmatched indices fall through to zero.
  always_comb begin
    q_a_o = '0;
    q_b_o = '0;
    for (int m = 0; m < INPUT_NUM_MEM; m++) begin
      if (run_i && sel == m) begin
        q_a_o = q_a_all_i[m*DATA_WIDTH +: DATA_WIDTH];
        q_b_o = q_b_all_i[m*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
endmodule

module conv_control_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int INPUT_NUM_MEM  = 5,
  parameter int IFMAP_PAR      = 1,
  parameter int CYCLES_PER_MEM = 9,
  parameter int OUT_PIXELS     = 784,
  parameter int RD_LATENCY     = 3,
  parameter int DRAIN_CYCLES   = 4,
  localparam int GROUPS        = (INPUT_NUM_MEM + IFMAP_PAR - 1) / IFMAP_PAR,
  localparam int PIXEL_CYCLES  = CYCLES_PER_MEM * GROUPS,
  localparam int CW            = (PIXEL_CYCLES > 1) ? $clog2(PIXEL_CYCLES) : 1,
  localparam int PW            = $clog2(OUT_PIXELS + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                go,
  input  logic                                stall,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all,
  output logic                                mem_rden,
  output logic                                addr_en,
  output logic                                mult_en,
  output logic                                clear_mult,
  output logic                                accum_sload,
  output logic [CW-1:0]                       count_sload,
  output logic [PW-1:0]                       pixel_count,
  output logic                                start,
  output logic                                conv_done,
  output logic                                busy,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_a_mux_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_b_mux_all
);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Degenerate zero-length phases collapse to a single cycle.
  localparam logic [LW-1:0] LAT_LAST = LW'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
  localparam logic [DW-1:0] DRN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(PIXEL_CYCLES - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(OUT_PIXELS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [DW-1:0] drn_q, drn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          go_acc;
  logic          run;

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      drn_q   <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      drn_q   <= drn_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  // Next-state sequencing; stall freezes everything except a fresh go.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    drn_d   = drn_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    start_d = 1'b0;
    done_d  = done_q;
    go_acc  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          go_acc  = 1'b1;
          state_d = S_PRIME;
          lat_d   = '0;
          drn_d   = '0;
          cnt_d   = '0;
          pix_d   = '0;
          done_d  = 1'b0;
        end
      end
      S_PRIME: begin
        if (!stall) begin
          if (lat_q == LAT_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            pix_d   = pix_q + 1'b1;
            start_d = (pix_q == '0);
            if (pix_q == PIX_LAST) begin
              state_d = S_DRAIN;
              drn_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (drn_q == DRN_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            drn_d = drn_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign run         = (state_q == S_RUN);
  assign mem_rden    = (state_q == S_PRIME) || run;
  assign addr_en     = mem_rden && !stall;
  assign mult_en     = (run || state_q == S_DRAIN) && !stall;
  assign busy        = mem_rden || (state_q == S_DRAIN);
  assign clear_mult  = go_acc && !reset;
  assign accum_sload = run && (cnt_q == '0);
  assign count_sload = cnt_q;
  assign pixel_count = pix_q;
  assign start       = start_q;
  assign conv_done   = done_q;

  for (genvar l = 0; l < IFMAP_PAR; l++) begin : g_lane
    conv_control_gen_lane #(
      .DATA_WIDTH    (DATA_WIDTH),
      .INPUT_NUM_MEM (INPUT_NUM_MEM),
      .IFMAP_PAR     (IFMAP_PAR),
      .CYCLES_PER_MEM(CYCLES_PER_MEM),
      .LANE          (l),
      .CW            (CW)
    ) u_lane (
      .run_i    (run),
      .cnt_i    (cnt_q),
      .q_a_all_i(in_feature_q_a_all),
      .q_b_all_i(in_feature_q_b_all),
      .q_a_o    (in_feature_q_a_mux_all[l*DATA_WIDTH +: DATA_WIDTH]),
      .q_b_o    (in_feature_q_b_mux_all[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_conv_control_gen.sv
// Bench for conv_control_gen: a small 3-memory/2-lane instance driven from a
// cycle plan, plus a default-parameter instance watched during the first frame.
module tb_conv_control_gen;
  logic clock = 1'b0, reset = 1'b0, go = 1'b0, stall = 1'b0;
  always #5 clock = ~clock;

  // Small instance: 3 memories, 2 lanes, 2 cycles/mem, 3 pixels.
  logic [23:0] s_qa = 24'h332211, s_qb = 24'hCCBBAA;
  logic        s_rden, s_addr, s_mult, s_clr, s_acc, s_start, s_done, s_busy;
  logic [1:0]  s_cnt, s_pix;
  logic [15:0] s_ma, s_mb;

  conv_control_gen #(
    .DATA_WIDTH(8), .INPUT_NUM_MEM(3), .IFMAP_PAR(2), .CYCLES_PER_MEM(2),
    .OUT_PIXELS(3), .RD_LATENCY(2), .DRAIN_CYCLES(3)
  ) u_dut (
    .clock(clock), .reset(reset), .go(go), .stall(stall),
    .in_feature_q_a_all(s_qa), .in_feature_q_b_all(s_qb),
    .mem_rden(s_rden), .addr_en(s_addr), .mult_en(s_mult), .clear_mult(s_clr),
    .accum_sload(s_acc), .count_sload(s_cnt), .pixel_count(s_pix),
    .start(s_start), .conv_done(s_done), .busy(s_busy),
    .in_feature_q_a_mux_all(s_ma), .in_feature_q_b_mux_all(s_mb)
  );

  // Default instance: 5 memories, 1 lane, 45 cycles/pixel.
  logic [39:0] d_qa = 40'h5544332211, d_qb = 40'hEEDDCCBBAA;
  logic        d_rden, d_addr, d_mult, d_clr, d_acc, d_start, d_done, d_busy;
  logic [5:0]  d_cnt;
  logic [9:0]  d_pix;
  logic [7:0]  d_ma, d_mb;

  conv_control_gen u_dut_def (
    .clock(clock), .reset(reset), .go(go), .stall(stall),
    .in_feature_q_a_all(d_qa), .in_feature_q_b_all(d_qb),
    .mem_rden(d_rden), .addr_en(d_addr), .mult_en(d_mult), .clear_mult(d_clr),
    .accum_sload(d_acc), .count_sload(d_cnt), .pixel_count(d_pix),
    .start(d_start), .conv_done(d_done), .busy(d_busy),
    .in_feature_q_a_mux_all(d_ma), .in_feature_q_b_mux_all(d_mb)
  );

  typedef struct {
    bit          go;
    bit          stall;
    logic [11:0] ctl;   // {rden,addr,mult,clr,acc,start,done,busy,cnt[1:0],pix[1:0]}
    logic [15:0] ma;
    logic [15:0] mb;
    bit          def_chk;
    logic [11:0] def_exp; // {clr,rden,acc,busy,mux_a[7:0]}
  } step_t;

  step_t plan_q[$];
  step_t exp_q[$];
  step_t mt;
  int    n_vec = 0, n_bad = 0;
  int    def_k = 0;
  bit    def_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Default instance timing from go: 3 PRIME cycles, then 45-cycle pixels
  // with memory m selected for counts 9m..9m+8.
  function automatic logic [11:0] def_model(input int k);
    int r;
    if (k == 0) return 12'h800;
    if (k < 4)  return 12'h500;
    r = (k - 4) % 45;
    return {2'b01, (r == 0), 1'b1, 8'(8'h11 * (r / 9 + 1))};
  endfunction

  task automatic add(input bit g, input bit s, input logic [7:0] c8,
                     input logic [1:0] cnt, input logic [1:0] pix,
                     input logic [15:0] ma, input logic [15:0] mb);
    step_t t;
    t.go = g; t.stall = s; t.ctl = {c8, cnt, pix}; t.ma = ma; t.mb = mb;
    t.def_chk = def_on;
    t.def_exp = def_on ? def_model(def_k) : 12'h0;
    if (def_on) def_k++;
    plan_q.push_back(t);
  endtask

  // Expected cycle trace of one frame. Indices count RUN cycles from 0.
  task automatic frame(input bit from_done, input int stall_at, input int stall_len,
                       input int go_run, input bit go_drain, input int abort_at,
                       input int done_hold);
    logic [15:0] ma, mb;
    bit acc, st;
    int idx;
    add(1'b1, 1'b0, from_done ? 8'b0001_0010 : 8'b0001_0000, 2'd0,
        from_done ? 2'd3 : 2'd0, 16'h0, 16'h0);
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 8'b1100_0001, 2'd0, 2'd0, 16'h0, 16'h0);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        idx = p * 4 + c;
        if (idx == abort_at) return;
        ma  = (c < 2) ? 16'h2211 : 16'h0033;
        mb  = (c < 2) ? 16'hBBAA : 16'h00CC;
        acc = (c == 0);
        st  = (p == 1 && c == 0);
        if (idx == stall_at) begin
          for (int k = 0; k < stall_len; k++) begin
            add(1'b0, 1'b1, {4'b1000, acc, st, 2'b01}, 2'(c), 2'(p), ma, mb);
            st = 1'b0;
          end
        end
        add(go_run == idx, 1'b0, {4'b1110, acc, st, 2'b01}, 2'(c), 2'(p), ma, mb);
      end
    end
    for (int d = 0; d < 3; d++)
      add(go_drain && d == 2, 1'b0, 8'b0010_0001, 2'd0, 2'd3, 16'h0, 16'h0);
    for (int d = 0; d < done_hold; d++)
      add(1'b0, 1'b0, 8'b0000_0010, 2'd0, 2'd3, 16'h0, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 16'h0, 16'h0);
  endtask

  // Drive the plan one cycle per entry, handing each expectation to the monitor.
  task automatic run_plan();
    step_t t;
    while (plan_q.size() > 0) begin
      @(posedge clock); #1;
      t = plan_q.pop_front();
      go = t.go; stall = t.stall;
      exp_q.push_back(t);
    end
    @(posedge clock); #1;
    go = 1'b0; stall = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({s_rden, s_addr, s_mult, s_clr, s_acc, s_start, s_done, s_busy, s_cnt, s_pix}), 32'd0);
    chk({tag, "_mux"}, {s_ma, s_mb}, 32'd0);
    chk({tag, "_def_ctl"}, 32'({d_rden, d_addr, d_mult, d_clr, d_acc, d_start, d_done, d_busy, d_cnt, d_pix}), 32'd0);
    chk({tag, "_def_mux"}, 32'({d_ma, d_mb}), 32'd0);
  endtask

  // Monitor: compare outputs mid-cycle against the queued expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mt = exp_q.pop_front();
      chk("ctl", 32'({s_rden, s_addr, s_mult, s_clr, s_acc, s_start, s_done, s_busy, s_cnt, s_pix}), 32'(mt.ctl));
      chk("mux_a", 32'(s_ma), 32'(mt.ma));
      chk("mux_b", 32'(s_mb), 32'(mt.mb));
      if (mt.def_chk) chk("def", 32'({d_clr, d_rden, d_acc, d_busy, d_ma}), 32'(mt.def_exp));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #12 chk_zero("reset");
    @(posedge clock); #1 reset = 1'b0;

    idle(3);
    run_plan();

    // Frame A: clean frame; default instance checked alongside.
    def_on = 1'b1; def_k = 0;
    frame(1'b0, -1, 0, -1, 1'b0, -1, 4);
    def_on = 1'b0;
    run_plan();

    // Frame B: restart from DONE, 5-cycle stall at pixel 1 count 1,
    // go in RUN and on the last DRAIN cycle both ignored.
    frame(1'b1, 5, 5, 8, 1'b1, -1, 3);
    run_plan();

    // Frame C: abandoned by reset while pixel_count is 1.
    frame(1'b1, -1, 0, -1, 1'b0, 6, 0);
    run_plan();
    chk("mid_pix_pre", 32'(s_pix), 32'd1);
    #1 reset = 1'b1;
    #1 chk_zero("mid_reset");
    @(posedge clock); #1 reset = 1'b0;

    // Frame D: clean frame after the abort.
    idle(2);
    frame(1'b0, -1, 0, -1, 1'b0, -1, 2);
    run_plan();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_control_gen.md
Name: conv_control_gen

Overview:
- Parametrised next-generation controller for the convolution datapath.
- Sequences feature/weight memory reads, address-generator enables, MAC accumulate-reload (sload) timing, and an N-memory to IFMAP_PAR-lane feature multiplexer across a full output frame.
- Adds an explicit FSM, go/restart handshake, stall, drain phase, and a generic mux for any memory count.
- Sits between the M9K feature/weight banks, the address generators and the DSP MAC array.

Parameters:
- DATA_WIDTH, 8, width of one feature word.
- INPUT_NUM_MEM, 5, number of input feature memories on the q buses.
- IFMAP_PAR, 1, number of parallel mux output lanes.
- CYCLES_PER_MEM, 9, MAC cycles spent on each memory group per output pixel.
- OUT_PIXELS, 784, output pixels per frame (out_width² × maps per MAC).
- RD_LATENCY, 3, cycles from read-enable to first valid data (PRIME length).
- DRAIN_CYCLES, 4, MAC pipeline flush cycles after the last pixel.
- Derived: GROUPS = ceil(INPUT_NUM_MEM/IFMAP_PAR); PIXEL_CYCLES = CYCLES_PER_MEM*GROUPS; CW = max(1,$clog2(PIXEL_CYCLES)); PW = $clog2(OUT_PIXELS+1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  start/restart request, sampled each cycle.
- stall  in  1  freeze sequencing while high.
- in_feature_q_a_all  in  DATA_WIDTH*INPUT_NUM_MEM  port-A data, memory m at bits [m*DATA_WIDTH +: DATA_WIDTH].
- in_feature_q_b_all  in  DATA_WIDTH*INPUT_NUM_MEM  port-B data, same packing.
- mem_rden  out  1  read enable for feature and weight memories, both ports.
- addr_en  out  1  enable to feature and weight address generators.
- mult_en  out  1  MAC enable.
- clear_mult  out  1  one-cycle MAC clear.
- accum_sload  out  1  accumulator reload, marks first cycle of a pixel.
- count_sload  out  CW  intra-pixel cycle counter.
- pixel_count  out  PW  completed pixels in the current frame.
- start  out  1  one-cycle pulse when the first pixel of a frame completes.
- conv_done  out  1  frame complete, level.
- busy  out  1  high in PRIME, RUN or DRAIN.
- in_feature_q_a_mux_all  out  DATA_WIDTH*IFMAP_PAR  lane-packed port-A mux output.
- in_feature_q_b_mux_all  out  DATA_WIDTH*IFMAP_PAR  lane-packed port-B mux output.

Behaviour:
- Reset, asynchronous: state=IDLE; all registered outputs 0; internal latency and drain counters 0.
- States: IDLE, PRIME, RUN, DRAIN, DONE. mem_rden=addr_en=busy=1 in PRIME and RUN.
- mult_en=1 in RUN and DRAIN, forced 0 while stall=1.
- IDLE or DONE, go=1: next state PRIME; clear_mult=1 for that cycle; conv_done, pixel_count, count_sload cleared; latency counter=0.
- go is ignored in PRIME, RUN and DRAIN.
- PRIME: latency counter increments each non-stalled cycle. At RD_LATENCY-1, next state RUN with count_sload=0.
- RUN: count_sload increments each non-stalled cycle and wraps PIXEL_CYCLES-1→0. On each wrap, pixel_count increments.
- start pulses on the wrap where pixel_count==0.
- On the wrap where pixel_count==OUT_PIXELS-1: pixel_count becomes OUT_PIXELS and next state is DRAIN.
- accum_sload = (state==RUN && count_sload==0), combinational.
- DRAIN: counts DRAIN_CYCLES non-stalled cycles, then DONE.
- DONE: conv_done=1 and held until go or reset.
- stall=1: all counters and state frozen; addr_en=0; mem_rden holds its value; go is still accepted in IDLE and DONE.
- Mux, combinational:
  - group g = count_sload / CYCLES_PER_MEM.
  - Lane l outputs memory m = g*IFMAP_PAR + l if m < INPUT_NUM_MEM and state==RUN.
  - Otherwise lane l outputs 0, including out-of-range lanes in the final group.
  - Ports A and B are muxed identically.
- Simultaneous go and the final DRAIN cycle: go ignored.
- Reset mid-frame: immediate return to IDLE; no conv_done.

Test Plan:
- Defaults, reset asserted then released, no go → all outputs 0, state IDLE; go=1 one cycle → clear_mult=1 that cycle, mem_rden=addr_en=busy=1 next cycle, first accum_sload 3 cycles later.
- INPUT_NUM_MEM=3, IFMAP_PAR=2, CYCLES_PER_MEM=2, OUT_PIXELS=3, RD_LATENCY=2, DRAIN_CYCLES=3; q_a memories = 0x11, 0x22, 0x33 → count_sload 0,1: lanes {0x22,0x11}; 2,3: lanes {0x00,0x33}; accum_sload every 4 cycles.
- Same config, full frame → 12 RUN cycles, start pulses once after the 4th RUN cycle, pixel_count=3, then 3 DRAIN cycles, then conv_done=1 held, busy=0.
- stall=1 for 5 cycles at count_sload=1 of pixel 1 → count_sload, pixel_count frozen; addr_en=mult_en=0; frame completes exactly 5 cycles later than unstalled.
- go pulsed during RUN → ignored; go in DONE → conv_done=0 next cycle, second frame repeats identical timing.
- reset asserted mid-RUN (pixel_count=1) → all outputs 0 asynchronously, no conv_done; subsequent go runs a clean full frame.
